// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_wr_arb : round-robin burst arbiter granting NREQ writers to one FIFO
// Revision    : 1.0
// ---------------------------------------------------------------------------
module fifo_wr_arb #(
   parameter int NREQ  = 4,
   parameter int DW    = 4,
   parameter int BURST = 4
) (
   input  logic                      wclk,
   input  logic                      reset_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*DW-1:0]        req_data,
   output logic [NREQ-1:0]           ack,
   input  logic                      full,
   output logic                      wren,
   output logic [DW-1:0]             wdata,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      busy
);

   localparam int OW = $clog2(NREQ);
   localparam int CW = $clog2(BURST) + 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   logic [0:0]    state;
   logic [0:0]    state_nxt;
   logic [OW-1:0] rr_ptr;
   logic [OW-1:0] grant_idx;
   logic [OW-1:0] owner_inc;
   logic [OW:0]   cand;
   logic [CW-1:0] cnt;
   logic          grant_vld;
   logic          req_own;
   logic          last_write;
   logic          burst_end;

   // Scan from farthest to nearest offset so the nearest set bit after rr_ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = {1'b0, rr_ptr} + (OW+1)'(i);
         if (cand >= (OW+1)'(NREQ)) cand = cand - (OW+1)'(NREQ);
         if (req[cand[OW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[OW-1:0];
         end
      end
   end

   assign req_own    = req[owner];
   assign last_write = (cnt == CW'(BURST - 1));
   assign burst_end  = (wren & last_write) | ~req_own;
   assign owner_inc  = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);

   always_ff @(posedge wclk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant_vld) state_nxt = S_BURST;
         S_BURST: if (burst_end) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy  = (state == S_BURST);
      wren  = busy & req_own & ~full;
      wdata = busy ? req_data[int'(owner)*DW +: DW] : '0;
      ack   = '0;
      if (wren) ack[owner] = 1'b1;
   end

   // A full stall leaves cnt, owner and state untouched, with no timeout.
   always_ff @(posedge wclk or negedge reset_n) begin
      if (!reset_n) begin
         owner  <= '0;
         rr_ptr <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  owner <= grant_idx;
                  cnt   <= '0;
               end
            end
            S_BURST: begin
               if (wren)      cnt    <= cnt + CW'(1);
               if (burst_end) rr_ptr <= owner_inc;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// Scoreboard bench for fifo_wr_arb: stimulus queues expected writes tagged with
// their cycle; a negedge monitor checks every write and per-cycle invariants.
module tb_fifo_wr_arb;

   logic        wclk;
   logic        reset_n;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic [3:0]  ack;
   logic        full;
   logic        wren;
   logic [3:0]  wdata;
   logic [1:0]  owner;
   logic        busy;

   fifo_wr_arb #(.NREQ(4), .DW(4), .BURST(4)) dut (
      .wclk     (wclk),
      .reset_n  (reset_n),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .full     (full),
      .wren     (wren),
      .wdata    (wdata),
      .owner    (owner),
      .busy     (busy)
   );

   typedef struct {
      int o;
      int d;
      int c;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_err  = 0;
   int   b;

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   always @(posedge wclk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int o, input int d, input int c);
      exp_t e;
      e.o = o;
      e.d = d;
      e.c = c;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge wclk);
      #1;
   endtask

   task automatic set_data(input int i, input int v);
      req_data[i*4 +: 4] = 4'(v);
   endtask

   task automatic do_reset();
      @(posedge wclk);
      #3 reset_n = 1'b0;
      req  = '0;
      full = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_wren", wren, 0);
      chk("rst_owner", owner, 0);
      @(posedge wclk);
      #4 reset_n = 1'b1;
      tick(1);
   endtask

   task automatic drain_check(input string name);
      tick(3);
      chk(name, sb.size(), 0);
      sb.delete();
   endtask

   always @(negedge wclk) begin
      exp_t e;
      chk("wren_while_full", int'(wren & full), 0);
      chk("ack_vs_wren", int'(ack), wren ? (1 << owner) : 0);
      if (!busy) chk("idle_wdata", int'(wdata), 0);
      while (sb.size() > 0 && sb[0].c < cyc) begin
         chk("missed_write_cycle", -1, sb[0].c);
         void'(sb.pop_front());
      end
      if (wren) begin
         if (sb.size() == 0) begin
            chk("unexpected_write_cycle", cyc, -1);
         end else begin
            e = sb.pop_front();
            chk("write_cycle", cyc, e.c);
            chk("write_owner", int'(owner), e.o);
            chk("write_data", int'(wdata), e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_n  = 1'b0;
      req      = '0;
      req_data = '0;
      full     = 1'b0;
      #2;
      chk("por_busy", busy, 0);
      chk("por_wren", wren, 0);
      chk("por_ack", int'(ack), 0);
      chk("por_wdata", int'(wdata), 0);

      // Single requester 1: two bursts of 4 separated by one bubble.
      do_reset();
      b = cyc;
      set_data(1, 5);
      req = 4'b0010;
      for (int k = 1; k <= 4; k++) push(1, 5, b + k);
      for (int k = 6; k <= 9; k++) push(1, 5, b + k);
      chk("s1_busy_pre", busy, 0);
      tick(1);
      chk("s1_busy", busy, 1);
      chk("s1_owner", int'(owner), 1);
      tick(4);
      chk("s1_bubble", busy, 0);
      tick(1);
      chk("s1_regrant_busy", busy, 1);
      chk("s1_regrant_owner", int'(owner), 1);
      tick(4);
      req = '0;
      drain_check("s1_pending");

      // All four requesting: owners 0,1,2,3,0 with one bubble each.
      do_reset();
      b = cyc;
      for (int i = 0; i < 4; i++) set_data(i, 8 + i);
      req = 4'b1111;
      for (int j = 0; j < 5; j++)
         for (int k = 0; k < 4; k++) push(j % 4, 8 + (j % 4), b + 1 + 5*j + k);
      for (int j = 0; j < 5; j++) begin
         tick(1);
         chk("s2_owner", int'(owner), j % 4);
         chk("s2_busy", busy, 1);
         tick(4);
         chk("s2_bubble", busy, 0);
      end
      req = '0;
      drain_check("s2_pending");

      // Full stall for 3 cycles after the 2nd write of owner 0.
      do_reset();
      b = cyc;
      set_data(0, 3);
      req = 4'b0001;
      push(0, 3, b + 1);
      push(0, 3, b + 2);
      push(0, 3, b + 6);
      push(0, 3, b + 7);
      tick(3);
      full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick(1);
         #1;
         chk("s3_stall_wren", wren, 0);
         chk("s3_stall_ack", int'(ack), 0);
         chk("s3_stall_busy", busy, 1);
      end
      tick(1);
      full = 1'b0;
      tick(2);
      chk("s3_end_busy", busy, 0);
      req = '0;
      drain_check("s3_pending");

      // Owner 2 drops its request after 2 writes; owner 3 follows.
      do_reset();
      b = cyc;
      set_data(2, 6);
      set_data(3, 7);
      req = 4'b1100;
      push(2, 6, b + 1);
      push(2, 6, b + 2);
      for (int k = 5; k <= 8; k++) push(3, 7, b + k);
      tick(1);
      chk("s4_owner2", int'(owner), 2);
      tick(2);
      req = 4'b1000;
      tick(1);
      chk("s4_idle", busy, 0);
      tick(1);
      chk("s4_busy", busy, 1);
      chk("s4_owner3", int'(owner), 3);
      tick(4);
      req = '0;
      drain_check("s4_pending");

      // Asynchronous reset mid-burst, then a fresh search from requester 0.
      do_reset();
      b = cyc;
      set_data(0, 9);
      req = 4'b0001;
      push(0, 9, b + 1);
      push(0, 9, b + 2);
      tick(3);
      #1 reset_n = 1'b0;
      #1;
      chk("s5_async_wren", wren, 0);
      chk("s5_async_ack", int'(ack), 0);
      chk("s5_async_busy", busy, 0);
      chk("s5_async_owner", int'(owner), 0);
      req = 4'b1000;
      set_data(3, 12);
      for (int k = 5; k <= 8; k++) push(3, 12, b + k);
      @(posedge wclk);
      #3 reset_n = 1'b1;
      tick(1);
      chk("s5_busy", busy, 1);
      chk("s5_owner3", int'(owner), 3);
      tick(4);
      req = '0;
      drain_check("s5_pending");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
